writeback_arbiter: RTL and testbench

Shares the single register-file write port between the in-order accessor pipeline and the multi-cycle mul/div unit. It also keeps a pending-destination scoreboard so decode can stall on hazards against mul/div results that are still in flight. It sits between the accessor/mul-div outputs and the register file, and drives the register file's `wen`/`waddr`/`wdata`.

---
 rtl/wb_pkg.sv | 18 +
 rtl/reg_scoreboard.sv | 44 ++++
 rtl/writeback_arbiter.sv | 100 ++++++++++
 tb/tb_writeback_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the writeback arbiter slice
package wb_pkg;

  localparam int WB_XLEN = 32;

  typedef logic [4:0]         reg_addr_t;
  typedef logic [WB_XLEN-1:0] word_t;

  // Tags which unit produced the write currently on the register-file port
  typedef enum logic [1:0] {
    SRC_NONE     = 2'd0,
    SRC_ACCESSOR = 2'd1,
    SRC_MULDIV   = 2'd2
  } src_e;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-destination scoreboard for in-flight mul/div results
module reg_scoreboard
  import wb_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t check_rs1,
  input  reg_addr_t check_rs2,
  input  reg_addr_t check_rd,
  output logic      hazard
);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_next;

  // Set is applied after clear so a re-issue in the commit cycle keeps the bit
  always_comb begin
    pending_next = pending;
    if (clr_en) begin
      pending_next[clr_addr] = 1'b0;
    end
    if (set_en && (set_addr != REG_ZERO)) begin
      pending_next[set_addr] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  assign hazard = pending[check_rs1] | pending[check_rs2] | pending[check_rd];

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - shares the register-file write port between accessor and mul/div
// Optional WB_ROUND_ROBIN_EN selects round-robin conflict resolution instead of mul/div priority.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            accessor_valid,
  output logic            accessor_ready,
  input  reg_addr_t       accessor_rd,
  input  logic [XLEN-1:0] accessor_rd_data,
  input  logic            muldiv_valid,
  output logic            muldiv_ready,
  input  reg_addr_t       muldiv_rd,
  input  logic [XLEN-1:0] muldiv_rd_data,
  input  logic            issue_valid,
  input  reg_addr_t       issue_rd,
  input  reg_addr_t       check_rs1,
  input  reg_addr_t       check_rs2,
  input  reg_addr_t       check_rd,
  output logic            hazard,
  output logic            wen,
  output reg_addr_t       waddr,
  output logic [XLEN-1:0] wdata
);

  logic            acc_req;
  logic            md_req;
  logic            acc_grant;
  logic            md_grant;
  reg_addr_t       sel_rd;
  logic [XLEN-1:0] sel_data;
  src_e            sel_src;
  src_e            src_q;

  assign acc_req = accessor_valid && !reset;
  assign md_req  = muldiv_valid && !reset;

`ifdef WB_ROUND_ROBIN_EN
  // favor_md high means mul/div wins the next conflict; reset favours the accessor
  logic favor_md;

  always_ff @(posedge clk) begin
    if (reset) begin
      favor_md <= 1'b0;
    end else if (acc_req && md_req) begin
      favor_md <= !favor_md;
    end
  end

  assign md_grant = md_req && (!acc_req || favor_md);
`else
  assign md_grant = md_req;
`endif

  assign acc_grant      = acc_req && !md_grant;
  assign accessor_ready = acc_grant;
  assign muldiv_ready   = md_grant;

  assign sel_rd   = md_grant ? muldiv_rd      : accessor_rd;
  assign sel_data = md_grant ? muldiv_rd_data : accessor_rd_data;
  assign sel_src  = md_grant ? SRC_MULDIV     : SRC_ACCESSOR;

  // A grant to x0 still consumes the result but suppresses the write enable
  always_ff @(posedge clk) begin
    if (reset) begin
      wen   <= 1'b0;
      waddr <= REG_ZERO;
      wdata <= '0;
      src_q <= SRC_NONE;
    end else if (acc_grant || md_grant) begin
      wen   <= (sel_rd != REG_ZERO);
      waddr <= sel_rd;
      wdata <= sel_data;
      src_q <= (sel_rd != REG_ZERO) ? sel_src : SRC_NONE;
    end else begin
      wen   <= 1'b0;
      src_q <= SRC_NONE;
    end
  end

  reg_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .set_en    (issue_valid),
    .set_addr  (issue_rd),
    .clr_en    (wen && (src_q == SRC_MULDIV)),
    .clr_addr  (waddr),
    .check_rs1 (check_rs1),
    .check_rs2 (check_rs2),
    .check_rd  (check_rd),
    .hazard    (hazard)
  );

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed self-checking bench for writeback_arbiter
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        accessor_valid;
  logic        accessor_ready;
  logic [4:0]  accessor_rd;
  logic [31:0] accessor_rd_data;
  logic        muldiv_valid;
  logic        muldiv_ready;
  logic [4:0]  muldiv_rd;
  logic [31:0] muldiv_rd_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  check_rs1;
  logic [4:0]  check_rs2;
  logic [4:0]  check_rd;
  logic        hazard;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  writeback_arbiter #(
    .XLEN (32),
    .NREG (32)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .accessor_valid   (accessor_valid),
    .accessor_ready   (accessor_ready),
    .accessor_rd      (accessor_rd),
    .accessor_rd_data (accessor_rd_data),
    .muldiv_valid     (muldiv_valid),
    .muldiv_ready     (muldiv_ready),
    .muldiv_rd        (muldiv_rd),
    .muldiv_rd_data   (muldiv_rd_data),
    .issue_valid      (issue_valid),
    .issue_rd         (issue_rd),
    .check_rs1        (check_rs1),
    .check_rs2        (check_rs2),
    .check_rd         (check_rd),
    .hazard           (hazard),
    .wen              (wen),
    .waddr            (waddr),
    .wdata            (wdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it; inputs change only here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    accessor_valid = 1'b0; accessor_rd = 5'd0; accessor_rd_data = 32'd0;
    muldiv_valid = 1'b0;   muldiv_rd = 5'd0;   muldiv_rd_data = 32'd0;
    issue_valid = 1'b0;    issue_rd = 5'd0;
    check_rs1 = 5'd0; check_rs2 = 5'd0; check_rd = 5'd0;
    tick();
    tick();

    // Readies stay low while reset is high, even with both valids up
    accessor_valid = 1'b1; muldiv_valid = 1'b1;
    #1;
    chk("rst_acc_ready", {31'd0, accessor_ready}, 32'd0);
    chk("rst_md_ready",  {31'd0, muldiv_ready},   32'd0);
    accessor_valid = 1'b0; muldiv_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("idle_wen",    {31'd0, wen}, 32'd0);
    chk("idle_waddr",  {27'd0, waddr}, 32'd0);
    chk("idle_wdata",  wdata, 32'd0);
    chk("idle_hazard", {31'd0, hazard}, 32'd0);
    chk("idle_acc_ready", {31'd0, accessor_ready}, 32'd0);
    chk("idle_md_ready",  {31'd0, muldiv_ready},   32'd0);

    // Accessor alone: rd=5 data=DEADBEEF
    accessor_valid = 1'b1; accessor_rd = 5'd5; accessor_rd_data = 32'hDEADBEEF;
    #1;
    chk("acc_ready", {31'd0, accessor_ready}, 32'd1);
    chk("acc_md_ready", {31'd0, muldiv_ready}, 32'd0);
    tick();
    accessor_valid = 1'b0;
    chk("acc_wen",   {31'd0, wen}, 32'd1);
    chk("acc_waddr", {27'd0, waddr}, 32'd5);
    chk("acc_wdata", wdata, 32'hDEADBEEF);
    tick();
    chk("acc_wen_drop",  {31'd0, wen}, 32'd0);
    chk("acc_waddr_hold", {27'd0, waddr}, 32'd5);
    chk("acc_wdata_hold", wdata, 32'hDEADBEEF);

    // Conflict for three cycles: accessor rd=3, mul/div rd=7
    accessor_valid = 1'b1; accessor_rd = 5'd3; accessor_rd_data = 32'hAAAA0003;
    muldiv_valid   = 1'b1; muldiv_rd   = 5'd7; muldiv_rd_data   = 32'hBBBB0007;
`ifdef WB_ROUND_ROBIN_EN
    #1;
    chk("c1_acc_ready", {31'd0, accessor_ready}, 32'd1);
    chk("c1_md_ready",  {31'd0, muldiv_ready},   32'd0);
    tick();
    chk("c1_waddr", {27'd0, waddr}, 32'd3);
    chk("c1_wdata", wdata, 32'hAAAA0003);
    chk("c2_acc_ready", {31'd0, accessor_ready}, 32'd0);
    chk("c2_md_ready",  {31'd0, muldiv_ready},   32'd1);
    tick();
    chk("c2_waddr", {27'd0, waddr}, 32'd7);
    chk("c2_wdata", wdata, 32'hBBBB0007);
    chk("c3_acc_ready", {31'd0, accessor_ready}, 32'd1);
    tick();
    chk("c3_waddr", {27'd0, waddr}, 32'd3);
`else
    #1;
    chk("c1_acc_ready", {31'd0, accessor_ready}, 32'd0);
    chk("c1_md_ready",  {31'd0, muldiv_ready},   32'd1);
    tick();
    chk("c1_waddr", {27'd0, waddr}, 32'd7);
    chk("c1_wdata", wdata, 32'hBBBB0007);
    chk("c2_acc_ready", {31'd0, accessor_ready}, 32'd0);
    tick();
    chk("c2_waddr", {27'd0, waddr}, 32'd7);
    chk("c3_md_ready", {31'd0, muldiv_ready}, 32'd1);
    tick();
    chk("c3_waddr", {27'd0, waddr}, 32'd7);
`endif
    chk("c3_wen", {31'd0, wen}, 32'd1);
    muldiv_valid = 1'b0;
    #1;
    chk("c4_acc_ready", {31'd0, accessor_ready}, 32'd1);
    tick();
    accessor_valid = 1'b0;
    chk("c4_waddr", {27'd0, waddr}, 32'd3);
    chk("c4_wdata", wdata, 32'hAAAA0003);
    tick();

    // Issue rd=9 with check_rs1=9 held; release after the mul/div commit
    check_rs1 = 5'd9;
    issue_valid = 1'b1; issue_rd = 5'd9;
    #1;
    chk("iss_hazard_n", {31'd0, hazard}, 32'd0);
    tick();
    issue_valid = 1'b0;
    chk("iss_hazard_n1", {31'd0, hazard}, 32'd1);
    tick();
    chk("iss_hazard_n2", {31'd0, hazard}, 32'd1);
    muldiv_valid = 1'b1; muldiv_rd = 5'd9; muldiv_rd_data = 32'h00000055;
    #1;
    chk("md9_ready", {31'd0, muldiv_ready}, 32'd1);
    chk("md9_hazard_m", {31'd0, hazard}, 32'd1);
    tick();
    muldiv_valid = 1'b0;
    chk("md9_wen_m1", {31'd0, wen}, 32'd1);
    chk("md9_waddr_m1", {27'd0, waddr}, 32'd9);
    chk("md9_wdata_m1", wdata, 32'h00000055);
    chk("md9_hazard_m1", {31'd0, hazard}, 32'd1);
    tick();
    chk("md9_hazard_m2", {31'd0, hazard}, 32'd0);
    chk("md9_wen_m2", {31'd0, wen}, 32'd0);

    // Accessor write to a pending register must not clear it (WAW via check_rd)
    check_rs1 = 5'd0; check_rd = 5'd12;
    issue_valid = 1'b1; issue_rd = 5'd12;
    tick();
    issue_valid = 1'b0;
    chk("waw_hazard", {31'd0, hazard}, 32'd1);
    accessor_valid = 1'b1; accessor_rd = 5'd12; accessor_rd_data = 32'h0000C0DE;
    tick();
    accessor_valid = 1'b0;
    chk("acc12_wen", {31'd0, wen}, 32'd1);
    tick();
    chk("acc12_hazard_kept", {31'd0, hazard}, 32'd1);
    muldiv_valid = 1'b1; muldiv_rd = 5'd12; muldiv_rd_data = 32'h12121212;
    tick();
    muldiv_valid = 1'b0;
    tick();
    chk("md12_hazard_clear", {31'd0, hazard}, 32'd0);
    check_rd = 5'd0;

    // Issue to x0 and a mul/div result to x0
    issue_valid = 1'b1; issue_rd = 5'd0;
    tick();
    issue_valid = 1'b0;
    chk("x0_hazard", {31'd0, hazard}, 32'd0);
    muldiv_valid = 1'b1; muldiv_rd = 5'd0; muldiv_rd_data = 32'h00001234;
    #1;
    chk("x0_md_ready", {31'd0, muldiv_ready}, 32'd1);
    tick();
    muldiv_valid = 1'b0;
    chk("x0_wen", {31'd0, wen}, 32'd0);
    chk("x0_hazard_after", {31'd0, hazard}, 32'd0);

    // Reset lands in the grant cycle with pending[9] set
    check_rs2 = 5'd9;
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0;
    chk("rr_pre_hazard", {31'd0, hazard}, 32'd1);
    muldiv_valid = 1'b1; muldiv_rd = 5'd9; muldiv_rd_data = 32'h99999999;
    reset = 1'b1;
    #1;
    chk("rr_md_ready", {31'd0, muldiv_ready}, 32'd0);
    tick();
    reset = 1'b0;
    muldiv_valid = 1'b0;
    chk("rr_wen",    {31'd0, wen}, 32'd0);
    chk("rr_waddr",  {27'd0, waddr}, 32'd0);
    chk("rr_hazard", {31'd0, hazard}, 32'd0);
    tick();
    chk("rr_hazard_late", {31'd0, hazard}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
